float_const_sub: RTL and testbench

Parametrised, multi-cycle IEEE-754 constant-minus-operand unit computing `float_out = CONST - float_in`. It is the generalised successor of the fixed 1.5-minus-x stage in the inverse-square-root Newton iteration. It supports arbitrary exponent/mantissa widths, a configurable constant, operands of either sign, selectable rounding and full special-value handling. It uses the same start/ready handshake as the rest of the InvSqrt datapath.

---
 rtl/float_pkg.sv | 39 +++
 rtl/float_classify.sv | 36 +++
 rtl/float_const_sub.sv | 198 +++++++++++++++++++
 tb/tb_float_const_sub.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/float_pkg.sv
// Shared types and constants for the parametrised float constant-subtract unit.
package float_pkg;

  localparam int DEF_EXP_W = 8;
  localparam int DEF_MAN_W = 23;

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_ALIGN,
    S_ADDSUB,
    S_NORM,
    S_ROUND,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    CLS_ZERO,
    CLS_NORMAL,
    CLS_INF,
    CLS_NAN
  } fclass_t;

  function automatic int bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Positive infinity, right-aligned in 64 bits; callers cast to their word width.
  function automatic logic [63:0] inf_const(input int exp_w, input int man_w);
    logic [63:0] ones;
    ones = (64'd1 << exp_w) - 64'd1;
    return ones << man_w;
  endfunction

  function automatic logic [63:0] qnan_const(input int exp_w, input int man_w);
    return inf_const(exp_w, man_w) | (64'd1 << (man_w - 1));
  endfunction

endpackage

// File: rtl/float_classify.sv
// Combinational unpack of one float word: sign, exponent, mantissa with hidden bit, class.
module float_classify
  import float_pkg::*;
#(
  parameter int EXP_W = DEF_EXP_W,
  parameter int MAN_W = DEF_MAN_W
) (
  input  logic [EXP_W+MAN_W:0] value,
  output logic                 sign,
  output logic [EXP_W-1:0]     exponent,
  output logic [MAN_W:0]       mantissa,
  output fclass_t              cls
);

  logic [EXP_W-1:0] raw_exp;
  logic [MAN_W-1:0] raw_frac;

  assign sign     = value[EXP_W+MAN_W];
  assign raw_exp  = value[EXP_W+MAN_W-1:MAN_W];
  assign raw_frac = value[MAN_W-1:0];

  // Subnormals are flushed: they report as zero with a cleared mantissa.
  always_comb begin
    cls      = CLS_NORMAL;
    exponent = raw_exp;
    mantissa = {1'b1, raw_frac};
    if (raw_exp == '1) begin
      cls = (raw_frac == '0) ? CLS_INF : CLS_NAN;
    end else if (raw_exp == '0) begin
      cls      = CLS_ZERO;
      exponent = '0;
      mantissa = '0;
    end
  end

endmodule

// File: rtl/float_const_sub.sv
// Multi-cycle IEEE-754 unit computing float_out = CONST - float_in with a start/ready handshake.
module float_const_sub
  import float_pkg::*;
#(
  parameter int                  EXP_W     = DEF_EXP_W,
  parameter int                  MAN_W     = DEF_MAN_W,
  parameter logic [EXP_W+MAN_W:0] CONST    = 32'h3FC00000,
  parameter bit                  ROUND_RNE = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [EXP_W+MAN_W:0] float_in,
  output logic [EXP_W+MAN_W:0] float_out,
  output logic                 ready
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int MW = MAN_W + 4;  // hidden + fraction + guard/round/sticky
  localparam int SW = MAN_W + 5;  // plus carry
  localparam logic [W-1:0]     QNAN      = W'(qnan_const(EXP_W, MAN_W));
  localparam logic [W-1:0]     INF_POS   = W'(inf_const(EXP_W, MAN_W));
  localparam logic [EXP_W-1:0] MAX_SHIFT = EXP_W'(MAN_W + 3);
  localparam logic [EXP_W:0]   EXP_ONES  = {1'b0, {EXP_W{1'b1}}};

  state_t state_reg, state_next;

  logic [W-1:0]     x_reg;
  logic [W-1:0]     out_reg;
  logic [MW-1:0]    big_reg, small_reg;
  logic [SW-1:0]    sum_reg;
  logic [EXP_W:0]   exp_reg;
  logic [EXP_W-1:0] diff_reg;
  logic             sign_reg, sub_reg, zero_reg;

  logic             x_sign, c_sign;
  logic [EXP_W-1:0] x_exp, c_exp;
  logic [MAN_W:0]   x_man, c_man;
  fclass_t          x_cls, c_cls;

  float_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_class_x (
    .value(x_reg), .sign(x_sign), .exponent(x_exp), .mantissa(x_man), .cls(x_cls)
  );

  float_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_class_c (
    .value(CONST), .sign(c_sign), .exponent(c_exp), .mantissa(c_man), .cls(c_cls)
  );

  // Special-value short cut taken from UNPACK.
  logic         special;
  logic [W-1:0] special_val;
  logic         x_bigger;

  assign x_bigger = {x_exp, x_man} > {c_exp, c_man};

  always_comb begin
    special     = 1'b1;
    special_val = '0;
    if (x_cls == CLS_NAN || c_cls == CLS_NAN) begin
      special_val = QNAN;
    end else if (x_cls == CLS_INF) begin
      special_val = {~x_sign, INF_POS[W-2:0]};
    end else if (x_cls == CLS_ZERO) begin
      special_val = CONST;
    end else begin
      special = 1'b0;
    end
  end

  // Alignment: every bit shifted out of the small operand folds into sticky.
  logic [MW-1:0] aligned, shifted, lost_mask;

  always_comb begin
    shifted   = small_reg >> diff_reg;
    lost_mask = ~({MW{1'b1}} << diff_reg);
    if (diff_reg > MAX_SHIFT) begin
      aligned = {{(MW-1){1'b0}}, |small_reg};
    end else begin
      aligned = shifted | {{(MW-1){1'b0}}, |(small_reg & lost_mask)};
    end
  end

  logic [SW-1:0] sum_calc;

  assign sum_calc = sub_reg ? ({1'b0, big_reg} - {1'b0, small_reg})
                            : ({1'b0, big_reg} + {1'b0, small_reg});

  logic norm_carry, norm_zero, norm_hidden, norm_flush;

  assign norm_carry  = sum_reg[SW-1];
  assign norm_zero   = (sum_reg == '0);
  assign norm_hidden = sum_reg[SW-2];
  assign norm_flush  = (exp_reg <= (EXP_W+1)'(1));

  // Rounding and packing of the normalised sum.
  logic             round_inc;
  logic [MAN_W+1:0] man_rounded;
  logic [EXP_W:0]   exp_rounded;
  logic [MAN_W-1:0] frac_rounded;
  logic [W-1:0]     round_val;

  always_comb begin
    round_inc    = ROUND_RNE && sum_reg[2] && (sum_reg[1] || sum_reg[0] || sum_reg[3]);
    man_rounded  = {1'b0, sum_reg[SW-2:3]} + (MAN_W+2)'(round_inc);
    exp_rounded  = exp_reg + {{EXP_W{1'b0}}, man_rounded[MAN_W+1]};
    frac_rounded = man_rounded[MAN_W+1] ? man_rounded[MAN_W:1] : man_rounded[MAN_W-1:0];
    round_val    = {sign_reg, exp_rounded[EXP_W-1:0], frac_rounded};
    if (zero_reg) begin
      round_val = '0;
    end else if (exp_rounded >= EXP_ONES) begin
      round_val = {sign_reg, INF_POS[W-2:0]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE, S_DONE: if (start) state_next = S_UNPACK;
      S_UNPACK:       state_next = special ? S_DONE : S_ALIGN;
      S_ALIGN:        state_next = S_ADDSUB;
      S_ADDSUB:       state_next = S_NORM;
      S_NORM: begin
        if (norm_carry || norm_zero || norm_hidden || norm_flush) state_next = S_ROUND;
      end
      S_ROUND:        state_next = S_DONE;
      default:        state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_reg     <= '0;
      out_reg   <= '0;
      big_reg   <= '0;
      small_reg <= '0;
      sum_reg   <= '0;
      exp_reg   <= '0;
      diff_reg  <= '0;
      sign_reg  <= 1'b0;
      sub_reg   <= 1'b0;
      zero_reg  <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE, S_DONE: if (start) x_reg <= float_in;
        S_UNPACK: begin
          zero_reg <= 1'b0;
          sub_reg  <= c_sign ^ ~x_sign;
          if (special) begin
            out_reg <= special_val;
          end else if (x_bigger) begin
            big_reg   <= {x_man, 3'b000};
            small_reg <= {c_man, 3'b000};
            exp_reg   <= {1'b0, x_exp};
            diff_reg  <= x_exp - c_exp;
            sign_reg  <= ~x_sign;
          end else begin
            big_reg   <= {c_man, 3'b000};
            small_reg <= {x_man, 3'b000};
            exp_reg   <= {1'b0, c_exp};
            diff_reg  <= c_exp - x_exp;
            sign_reg  <= c_sign;
          end
        end
        S_ALIGN:  small_reg <= aligned;
        S_ADDSUB: sum_reg   <= sum_calc;
        S_NORM: begin
          if (norm_carry) begin
            sum_reg <= {1'b0, sum_reg[SW-1:2], sum_reg[1] | sum_reg[0]};
            exp_reg <= exp_reg + (EXP_W+1)'(1);
          end else if (norm_zero) begin
            zero_reg <= 1'b1;
          end else if (!norm_hidden) begin
            if (norm_flush) begin
              zero_reg <= 1'b1;
            end else begin
              sum_reg <= sum_reg << 1;
              exp_reg <= exp_reg - (EXP_W+1)'(1);
            end
          end
        end
        S_ROUND:  out_reg <= round_val;
        default: ;
      endcase
    end
  end

  assign float_out = out_reg;
  assign ready     = (state_reg == S_DONE);

endmodule

// File: tb/tb_float_const_sub.sv
// Scoreboard bench for float_const_sub: default, truncating and half-precision instances.
module tb_float_const_sub;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
  logic [31:0] fin0 = '0, fin1 = '0;
  logic [15:0] fin2 = '0;
  logic [31:0] fout0, fout1;
  logic [15:0] fout2;
  logic        rdy0, rdy1, rdy2;

  float_const_sub dut0 (
    .clk(clk), .rst(rst), .start(start0), .float_in(fin0), .float_out(fout0), .ready(rdy0)
  );

  float_const_sub #(.ROUND_RNE(1'b0)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .float_in(fin1), .float_out(fout1), .ready(rdy1)
  );

  float_const_sub #(.EXP_W(5), .MAN_W(10), .CONST(16'h3E00)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .float_in(fin2), .float_out(fout2), .ready(rdy2)
  );

  typedef struct {
    logic [31:0] val;
    int          edge0;
    int          lat;
    string       name;
  } exp_t;

  exp_t q0[$], q1[$], q2[$];
  int edge_cnt = 0;
  int n_checks = 0;
  int n_fail   = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, got, want);
    end
  endtask

  task automatic score(input int u, input logic [31:0] got);
    exp_t e;
    logic found;
    found = 1'b0;
    case (u)
      0: if (q0.size() > 0) begin e = q0.pop_front(); found = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); found = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); found = 1'b1; end
    endcase
    if (!found) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_ready unit %0d: got %h, expected no result", u, got);
    end else begin
      $display("unit %0d %s: out=%h latency=%0d", u, e.name, got, edge_cnt - e.edge0);
      check({e.name, " value"}, got, e.val);
      check({e.name, " latency"}, 32'(edge_cnt - e.edge0), 32'(e.lat));
    end
  endtask

  logic p0 = 1'b0, p1 = 1'b0, p2 = 1'b0;
  always @(negedge clk) begin
    if (rdy0 && !p0) score(0, fout0);
    if (rdy1 && !p1) score(1, fout1);
    if (rdy2 && !p2) score(2, {16'h0000, fout2});
    p0 = rdy0;
    p1 = rdy1;
    p2 = rdy2;
  end

  task automatic drive(input int u, input logic [31:0] x, input logic s);
    case (u)
      0: begin fin0 = x; start0 = s; end
      1: begin fin1 = x; start1 = s; end
      default: begin fin2 = x[15:0]; start2 = s; end
    endcase
  endtask

  task automatic push(input int u, input exp_t e);
    case (u)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic issue(input int u, input logic [31:0] x, input logic [31:0] want,
                       input int lat, input string nm);
    @(negedge clk);
    drive(u, x, 1'b1);
    @(posedge clk);
    #1;
    push(u, '{want, edge_cnt, lat, nm});
    @(negedge clk);
    drive(u, x, 1'b0);
  endtask

  task automatic drain();
    int pending;
    for (int i = 0; i < 100 && (q0.size() + q1.size() + q2.size()) != 0; i++) @(negedge clk);
    @(negedge clk);
    pending = q0.size() + q1.size() + q2.size();
    if (pending != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: got %0d pending results, expected 0", pending);
      q0.delete();
      q1.delete();
      q2.delete();
    end
  endtask

  logic [31:0] tv_x [10] = '{32'h3F000000, 32'h3FC00000, 32'h40000000, 32'hC0000000,
                             32'h30800000, 32'hBFC00000, 32'h7F800000, 32'hFFC00001,
                             32'h00000001, 32'hFF800000};
  logic [31:0] tv_e [10] = '{32'h3F800000, 32'h00000000, 32'hBF000000, 32'h40600000,
                             32'h3FC00000, 32'h40400000, 32'hFF800000, 32'h7FC00000,
                             32'h3FC00000, 32'h7F800000};
  int          tv_l [10] = '{5, 5, 7, 5, 5, 5, 1, 1, 1, 1};

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset ready", {31'b0, rdy0}, 32'd0);
    check("reset out", fout0, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("idle ready", {31'b0, rdy0}, 32'd0);

    issue(0, 32'h3F800000, 32'h3F000000, 6, "one");
    drain();
    repeat (3) @(negedge clk);
    check("hold out", fout0, 32'h3F000000);
    check("hold ready", {31'b0, rdy0}, 32'd1);

    for (int i = 0; i < 10; i++) begin
      issue(0, tv_x[i], tv_e[i], tv_l[i], $sformatf("vec%0d", i));
      drain();
    end

    issue(1, 32'h30800000, 32'h3FBFFFFF, 5, "trunc");
    drain();
    issue(2, 32'h00003C00, 32'h00003800, 6, "half");
    drain();

    // start pulses at edges 2 and 4 must be ignored while busy
    @(negedge clk);
    fin0 = 32'h3F800000;
    start0 = 1'b1;
    @(posedge clk);
    #1;
    push(0, '{32'h3F000000, edge_cnt, 6, "busy_ignore"});
    @(negedge clk); start0 = 1'b0; fin0 = 32'h40000000;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    drain();

    // start held high across DONE chains two operations
    @(negedge clk);
    fin0 = 32'h3F000000;
    start0 = 1'b1;
    @(posedge clk);
    #1;
    push(0, '{32'h3F800000, edge_cnt, 5, "b2b_a"});
    for (int i = 0; i < 20 && !rdy0; i++) @(negedge clk);
    fin0 = 32'h40000000;
    @(posedge clk);
    #1;
    push(0, '{32'hBF000000, edge_cnt, 7, "b2b_b"});
    check("b2b ready drop", {31'b0, rdy0}, 32'd0);
    @(negedge clk);
    start0 = 1'b0;
    drain();

    // asynchronous reset while dut0 sits in NORM
    @(negedge clk);
    fin0 = 32'h40000000;
    start0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midreset ready", {31'b0, rdy0}, 32'd0);
    check("midreset out", fout0, 32'h0);
    check("midreset ready unit1", {31'b0, rdy1}, 32'd0);
    check("midreset out unit2", {16'h0000, fout2}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post reset ready", {31'b0, rdy0}, 32'd0);

    issue(0, 32'h3F800000, 32'h3F000000, 6, "after_reset");
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected completion within 200000 time units");
    $fatal(1, "simulation stalled");
  end

endmodule
